// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register of the RV32I core.
//   Owns the fetch PC. Keeps at most one instruction-memory request in flight.
//   Buffers a response that arrives while the pipe is held. Squashes in-flight
//   fetches on an execute-stage redirect.
//
// Ports
//   clk, reset           core clock, synchronous active-high reset
//   stall_fetch          hold fetch PC (hazard unit)
//   stall_decode         hold IF/ID register (hazard unit)
//   flush_decode         replace IF/ID contents with a bubble
//   pc_src_ex            taken branch/jump redirect from execute
//   pc_target_ex         redirect target (low two bits ignored)
//   imem_req_*           request channel (valid/ready), word-aligned address
//   imem_resp_*          response channel (valid only, no backpressure)
//   instr_d, pc_d,
//   pc_plus4_d, valid_d  IF/ID register contents presented to decode
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_fetch,
    input  logic        stall_decode,
    input  logic        flush_decode,
    input  logic        pc_src_ex,
    input  logic [31:0] pc_target_ex,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d;
    // Holding buffer: only meaningful while in S_HOLD, so no separate valid bit.
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic        hold;
    logic        load_ifid;
    logic [31:0] load_instr, load_pc;

    always_comb begin
        hold        = stall_fetch | stall_decode;
        state_d     = state_q;
        pc_f_d      = pc_f_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        load_ifid   = 1'b0;
        load_instr  = buf_instr_q;
        load_pc     = buf_pc_q;

        unique case (state_q)
            S_REQ: begin
                // Responses are ignored here; only a new handshake matters.
                if (imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (!hold) begin
                        load_ifid  = 1'b1;
                        load_instr = imem_resp_data;
                        load_pc    = pc_f_q;
                        pc_f_d     = pc_f_q + 32'd4;
                        state_d    = S_REQ;
                    end else begin
                        buf_instr_d = imem_resp_data;
                        buf_pc_d    = pc_f_q;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!hold) begin
                    load_ifid = 1'b1;
                    pc_f_d    = pc_f_q + 32'd4;
                    state_d   = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_resp_valid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        // Redirect overrides everything above. An accepted-but-unanswered
        // request must still be drained in S_DROP before fetching again.
        if (pc_src_ex) begin
            pc_f_d      = pc_target_ex & ~32'h3;
            load_ifid   = 1'b0;
            buf_instr_d = '0;
            buf_pc_d    = '0;
            unique case (state_q)
                S_REQ:          state_d = imem_req_ready  ? S_DROP : S_REQ;
                S_WAIT, S_DROP: state_d = imem_resp_valid ? S_REQ  : S_DROP;
                default:        state_d = S_REQ;
            endcase
        end

        // IF/ID: flush/redirect bubble beats stall; a write only happens
        // when not held, so load and stall_decode never coincide.
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        if (flush_decode || pc_src_ex) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else if (load_ifid) begin
            ifid_instr_d = load_instr;
            ifid_pc_d    = load_pc;
            ifid_pc4_d   = load_pc + 32'd4;
            ifid_valid_d = 1'b1;
        end else if (!stall_decode) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_REQ;
            pc_f_q       <= RESET_PC;
            buf_instr_q  <= '0;
            buf_pc_q     <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_f_q       <= pc_f_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc_q     <= buf_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = {pc_f_q[31:2], 2'b00};
    assign instr_d        = ifid_instr_q;
    assign pc_d           = ifid_pc_q;
    assign pc_plus4_d     = ifid_pc4_q;
    assign valid_d        = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. A small instruction-memory model inside the
// cycle task answers each accepted request after `lat` cycles with
// addr ^ 32'hA5A5_0000. It shares the DUT reset.
module tb_fetch_stage;
    logic        clk;
    logic        reset;
    logic        stall_fetch, stall_decode, flush_decode, pc_src_ex;
    logic [31:0] pc_target_ex;
    logic        imem_req_valid, imem_req_ready, imem_resp_valid;
    logic [31:0] imem_req_addr, imem_resp_data;
    logic [31:0] instr_d, pc_d, pc_plus4_d;
    logic        valid_d;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat, cnt;
    logic        pend;
    logic [31:0] p_addr;

    fetch_stage dut (
        .clk(clk), .reset(reset),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode),
        .flush_decode(flush_decode), .pc_src_ex(pc_src_ex),
        .pc_target_ex(pc_target_ex),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .valid_d(valid_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; returns at edge+1 with memory outputs updated.
    task automatic cyc();
        logic        acc, rst_s;
        logic [31:0] a;
        #1;
        acc   = imem_req_valid & imem_req_ready;
        a     = imem_req_addr;
        rst_s = reset;
        @(posedge clk);
        #1;
        imem_resp_valid = 1'b0;
        if (rst_s) begin
            pend = 1'b0;
        end else begin
            if (acc) begin
                pend   = 1'b1;
                p_addr = a;
                cnt    = lat;
            end
            if (pend) begin
                if (cnt <= 1) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = p_addr ^ 32'hA5A5_0000;
                    pend            = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; stall_fetch = 1'b0; stall_decode = 1'b0; flush_decode = 1'b0;
        pc_src_ex = 1'b0; pc_target_ex = '0; imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0; imem_resp_data = '0;
        lat = 1; cnt = 0; pend = 1'b0; p_addr = '0;

        // Reset state
        cyc(); cyc();
        chk("rst_req_valid", imem_req_valid, 1);
        chk("rst_req_addr",  imem_req_addr, 32'h0);
        chk("rst_instr",     instr_d, 32'h0000_0013);
        chk("rst_pc",        pc_d, 32'h0);
        chk("rst_pc4",       pc_plus4_d, 32'h0);
        chk("rst_valid",     valid_d, 0);
        reset = 1'b0;

        // 1: streaming fetch, 1-cycle latency
        cyc();
        chk("t1_wait_noreq", imem_req_valid, 0);
        cyc();
        chk("t1_i0_instr", instr_d, 32'hA5A5_0000);
        chk("t1_i0_pc",    pc_d, 32'h0);
        chk("t1_i0_pc4",   pc_plus4_d, 32'h4);
        chk("t1_i0_valid", valid_d, 1);
        chk("t1_req4",     imem_req_addr, 32'h4);
        cyc();
        chk("t1_bubble_valid", valid_d, 0);
        chk("t1_bubble_instr", instr_d, 32'h0000_0013);
        chk("t1_bubble_pc",    pc_d, 32'h0);
        cyc();
        chk("t1_i4_instr", instr_d, 32'hA5A5_0004);
        chk("t1_i4_pc4",   pc_plus4_d, 32'h8);
        cyc(); cyc();
        chk("t1_i8_instr", instr_d, 32'hA5A5_0008);
        chk("t1_i8_pc",    pc_d, 32'h8);
        chk("t1_i8_valid", valid_d, 1);
        cyc(); cyc();
        chk("t1_req10", imem_req_addr, 32'h10);

        // 2: response for 0x10 arrives while held
        stall_fetch = 1'b1; stall_decode = 1'b1;
        cyc();
        chk("t2_accept_keep", instr_d, 32'hA5A5_000C);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t2_hold_instr", instr_d, 32'hA5A5_000C);
            chk("t2_hold_pc",    pc_d, 32'hC);
            chk("t2_hold_valid", valid_d, 1);
            chk("t2_hold_noreq", imem_req_valid, 0);
        end
        stall_fetch = 1'b0; stall_decode = 1'b0;
        cyc();
        chk("t2_rel_instr", instr_d, 32'hA5A5_0010);
        chk("t2_rel_pc",    pc_d, 32'h10);
        chk("t2_rel_valid", valid_d, 1);
        chk("t2_rel_req",   imem_req_valid, 1);
        chk("t2_rel_addr",  imem_req_addr, 32'h14);

        // 3: redirect while waiting for 0x20 (slow memory)
        cyc(); cyc(); cyc(); cyc(); cyc(); cyc();
        chk("t3_pc1c",   pc_d, 32'h1C);
        chk("t3_req20",  imem_req_addr, 32'h20);
        lat = 3;
        cyc();
        chk("t3_wait", imem_req_valid, 0);
        pc_src_ex = 1'b1; pc_target_ex = 32'h0000_0203;
        cyc();
        chk("t3_drop_noreq", imem_req_valid, 0);
        chk("t3_drop_valid", valid_d, 0);
        chk("t3_drop_instr", instr_d, 32'h0000_0013);
        pc_src_ex = 1'b0;
        cyc();
        chk("t3_drop2_noreq", imem_req_valid, 0);
        cyc();
        chk("t3_discard_valid", valid_d, 0);
        chk("t3_discard_instr", instr_d, 32'h0000_0013);
        chk("t3_req_valid",     imem_req_valid, 1);
        chk("t3_req200",        imem_req_addr, 32'h200);
        lat = 1;
        cyc();
        chk("t3_still_bubble", valid_d, 0);
        cyc();
        chk("t3_i200_instr", instr_d, 32'hA5A5_0200);
        chk("t3_i200_pc",    pc_d, 32'h200);
        chk("t3_i200_valid", valid_d, 1);

        // 4: redirect in same cycle as the response
        cyc();
        pc_src_ex = 1'b1; pc_target_ex = 32'h0000_0300;
        cyc();
        chk("t4_req_valid", imem_req_valid, 1);
        chk("t4_req300",    imem_req_addr, 32'h300);
        chk("t4_valid",     valid_d, 0);
        chk("t4_pc_keep",   pc_d, 32'h200);
        pc_src_ex = 1'b0;
        cyc(); cyc();
        chk("t4_i300_instr", instr_d, 32'hA5A5_0300);
        chk("t4_i300_pc",    pc_d, 32'h300);

        // 5: flush beats stall; fetch unaffected
        imem_req_ready = 1'b0; flush_decode = 1'b1; stall_decode = 1'b1;
        cyc();
        chk("t5_instr",   instr_d, 32'h0000_0013);
        chk("t5_valid",   valid_d, 0);
        chk("t5_pc_keep", pc_d, 32'h300);
        chk("t5_pc4",     pc_plus4_d, 32'h304);
        chk("t5_req",     imem_req_valid, 1);
        chk("t5_addr",    imem_req_addr, 32'h304);
        flush_decode = 1'b0; stall_decode = 1'b0;

        // 6: wrap at top of address space, then reset during WAIT
        pc_src_ex = 1'b1; pc_target_ex = 32'hFFFF_FFFC;
        cyc();
        chk("t6_addr_top", imem_req_addr, 32'hFFFF_FFFC);
        pc_src_ex = 1'b0; imem_req_ready = 1'b1;
        cyc(); cyc();
        chk("t6_instr", instr_d, 32'h5A5A_FFFC);
        chk("t6_pc",    pc_d, 32'hFFFF_FFFC);
        chk("t6_pc4",   pc_plus4_d, 32'h0);
        chk("t6_valid", valid_d, 1);
        chk("t6_wrap",  imem_req_addr, 32'h0);
        lat = 3;
        cyc();
        chk("t6_wait", imem_req_valid, 0);
        reset = 1'b1;
        cyc();
        chk("t6_rst_req",   imem_req_valid, 1);
        chk("t6_rst_addr",  imem_req_addr, 32'h0);
        chk("t6_rst_instr", instr_d, 32'h0000_0013);
        chk("t6_rst_pc",    pc_d, 32'h0);
        chk("t6_rst_pc4",   pc_plus4_d, 32'h0);
        chk("t6_rst_valid", valid_d, 0);
        reset = 1'b0; lat = 1;
        cyc(); cyc();
        chk("t6_post_instr", instr_d, 32'hA5A5_0000);
        chk("t6_post_valid", valid_d, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
